// File: rtl/tone_voice.sv
// tone_voice: single-voice wavetable tone generator. A rate divider steps the
// wavetable address while a linear attack/release envelope scales each sample.
module tone_voice #(
  parameter int          DIV_W    = 11,
  parameter int          ADDR_W   = 9,
  parameter int          ENV_DIV  = 64,
  parameter int          ATK_STEP = 8,
  parameter int          REL_STEP = 4,
  parameter logic [15:0] SILENT   = 16'h7FFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gate,
  input  logic [DIV_W-1:0]  div_num,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [15:0]       ram_rdata,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic [7:0]        env_level,
  output logic              busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ATTACK  = 2'd1;
  localparam logic [1:0] S_SUSTAIN = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam int               PRE_W    = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(ENV_DIV - 1);
  localparam logic signed [25:0] SILENT_W = 26'(SILENT);

  logic [1:0]          state, state_nx;
  logic [7:0]          env_nx;
  logic [PRE_W-1:0]    env_pre;
  logic                env_tick;
  logic                gate_q, gate_d, gate_rise, gate_fall;
  logic [8:0]          atk_sum;
  logic [7:0]          atk_val, rel_val;
  logic [DIV_W-1:0]    cnt, eff_div;
  logic                div_term, step, to_idle;
  logic                v0, v1, v2;
  logic signed [16:0]  diff;
  logic signed [25:0]  diff_w, env_w, prod_nx, prod_q;

  assign gate_rise = gate_q & ~gate_d;
  assign gate_fall = ~gate_q & gate_d;
  assign env_tick  = (env_pre == PRE_LAST);
  assign atk_sum   = {1'b0, env_level} + 9'(ATK_STEP);
  assign atk_val   = atk_sum[8] ? 8'hFF : atk_sum[7:0];
  assign rel_val   = ({1'b0, env_level} > 9'(REL_STEP)) ? (env_level - 8'(REL_STEP)) : 8'h00;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    env_nx   = env_level;
    case (state)
      S_IDLE: begin
        if (gate_rise) begin
          state_nx = S_ATTACK;
          env_nx   = 8'h00;
        end
      end
      S_ATTACK: begin
        if (gate_fall) begin
          state_nx = S_RELEASE;
        end else if (env_tick) begin
          env_nx = atk_val;
          if (atk_val == 8'hFF) state_nx = S_SUSTAIN;
        end
      end
      S_SUSTAIN: begin
        env_nx = 8'hFF;
        if (gate_fall) state_nx = S_RELEASE;
      end
      S_RELEASE: begin
        // Retrigger resumes the attack from the current level, no phase reset.
        if (gate_rise) begin
          state_nx = S_ATTACK;
        end else if (env_tick) begin
          env_nx = rel_val;
          if (rel_val == 8'h00) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      env_level <= 8'h00;
      env_pre   <= '0;
      gate_q    <= 1'b0;
      gate_d    <= 1'b0;
    end else begin
      state     <= state_nx;
      env_level <= env_nx;
      gate_q    <= gate;
      gate_d    <= gate_q;
      if (state_nx != state || state == S_IDLE || env_tick) env_pre <= '0;
      else env_pre <= env_pre + 1'b1;
    end
  end

  // Terminal compare uses >= so a shortened div_num ends the period at once.
  assign eff_div  = (div_num < DIV_W'(2)) ? DIV_W'(2) : div_num;
  assign div_term = (cnt >= eff_div - DIV_W'(1));
  assign step     = (state != S_IDLE) && div_term;
  assign to_idle  = (state != S_IDLE) && (state_nx == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      ram_addr <= '0;
    end else if (state == S_IDLE) begin
      if (gate_rise) begin
        cnt      <= '0;
        ram_addr <= '0;
      end
    end else if (div_term) begin
      cnt      <= '0;
      ram_addr <= ram_addr + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign diff    = $signed({1'b0, ram_rdata}) - $signed({1'b0, SILENT});
  assign diff_w  = 26'(diff);
  assign env_w   = 26'({1'b0, env_level});
  assign prod_nx = diff_w * env_w;

  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE || to_idle) begin
      v0           <= 1'b0;
      v1           <= 1'b0;
      v2           <= 1'b0;
      prod_q       <= '0;
      sample_valid <= 1'b0;
      sample_out   <= SILENT;
    end else begin
      v0           <= step;
      v1           <= v0;
      v2           <= v1;
      sample_valid <= v2;
      if (v1) prod_q <= prod_nx;
      if (v2) sample_out <= 16'((prod_q >>> 8) + SILENT_W);
    end
  end

endmodule

// File: tb/tb_tone_voice.sv
// tb_tone_voice: directed plus randomized stimulus for tone_voice, checked
// every clock against a queue-based behavioural model of the voice.
module tb_tone_voice;
  localparam int ENV_DIV  = 2;
  localparam int ATK_STEP = 64;
  localparam int REL_STEP = 100;
  localparam int SIL      = 32767;

  logic        clk = 1'b0;
  logic        rst, gate;
  logic [10:0] div_num;
  logic [8:0]  ram_addr;
  logic [15:0] ram_rdata, sample_out;
  logic        sample_valid, busy;
  logic [7:0]  env_level;
  logic [15:0] mem [512];

  int vectors = 0;
  int errors  = 0;

  typedef struct {int age; int addr; int env;} pend_t;
  pend_t pq[$];
  int m_g1, m_g2, m_ph, m_env, m_pre, m_cnt, m_addr, m_sout, m_sval;

  tone_voice #(.ENV_DIV(ENV_DIV), .ATK_STEP(ATK_STEP), .REL_STEP(REL_STEP)) dut (
    .clk(clk), .rst(rst), .gate(gate), .div_num(div_num), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .sample_out(sample_out), .sample_valid(sample_valid),
    .env_level(env_level), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ram_rdata <= mem[ram_addr];

  function automatic int floor_div256(input int x);
    return (x >= 0) ? x / 256 : -((-x + 255) / 256);
  endfunction

  // Phases: 0 idle, 1 attack, 2 sustain, 3 release.
  function automatic void model_edge(input bit r, input bit g, input int div);
    int rise, fall, tick, nph, nenv, eff, step;
    if (r) begin
      m_g1 = 0; m_g2 = 0; m_ph = 0; m_env = 0; m_pre = 0;
      m_cnt = 0; m_addr = 0; m_sout = SIL; m_sval = 0;
      pq.delete();
      return;
    end
    rise = (m_g1 == 1 && m_g2 == 0) ? 1 : 0;
    fall = (m_g1 == 0 && m_g2 == 1) ? 1 : 0;
    tick = (m_pre == ENV_DIV - 1) ? 1 : 0;
    nph = m_ph;
    nenv = m_env;
    case (m_ph)
      0: if (rise != 0) begin nph = 1; nenv = 0; end
      1: if (fall != 0) nph = 3;
         else if (tick != 0) begin
           nenv = (m_env + ATK_STEP > 255) ? 255 : m_env + ATK_STEP;
           if (nenv == 255) nph = 2;
         end
      2: if (fall != 0) nph = 3;
      default: if (rise != 0) nph = 1;
         else if (tick != 0) begin
           nenv = (m_env > REL_STEP) ? m_env - REL_STEP : 0;
           if (nenv == 0) nph = 0;
         end
    endcase
    step = 0;
    if (m_ph != 0) begin
      eff = (div < 2) ? 2 : div;
      if (m_cnt >= eff - 1) begin
        m_cnt = 0; m_addr = (m_addr + 1) % 512; step = 1;
      end else m_cnt = m_cnt + 1;
    end else if (rise != 0) begin
      m_addr = 0; m_cnt = 0;
    end
    if (m_ph == 0 || nph == 0) begin
      pq.delete();
      m_sout = SIL;
      m_sval = 0;
    end else begin
      m_sval = 0;
      foreach (pq[i]) begin
        pq[i].age = pq[i].age + 1;
        if (pq[i].age == 2) pq[i].env = m_env;
      end
      if (pq.size() > 0 && pq[0].age == 3) begin
        m_sout = SIL + floor_div256((int'(mem[pq[0].addr]) - SIL) * pq[0].env);
        m_sval = 1;
        void'(pq.pop_front());
      end
      if (step != 0) pq.push_back('{0, m_addr, 0});
    end
    if (nph != m_ph || m_ph == 0 || tick != 0) m_pre = 0;
    else m_pre = m_pre + 1;
    m_ph = nph;
    m_env = nenv;
    m_g2 = m_g1;
    m_g1 = g ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge(rst, gate, int'(div_num));
      #1;
      check("ram_addr", 16'(ram_addr), 16'(m_addr));
      check("env_level", 16'(env_level), 16'(m_env));
      check("busy", 16'(busy), 16'(m_ph != 0));
      check("sample_valid", 16'(sample_valid), 16'(m_sval));
      check("sample_out", sample_out, 16'(m_sout));
    end
  endtask

  task automatic fill(input logic [15:0] v);
    foreach (mem[i]) mem[i] = v;
  endtask

  initial begin
    int found;
    rst = 1'b1;
    gate = 1'b1;
    div_num = 11'd4;
    foreach (mem[i]) mem[i] = 16'($urandom);
    tick(3);
    rst = 1'b0;

    // div 4 long enough to wrap the address, then minimum-rate divisors
    tick(2100);
    div_num = 11'd0; tick(60);
    div_num = 11'd1; tick(60);
    for (int i = 0; i < 40; i++) begin
      div_num = 11'($urandom_range(0, 9));
      tick(int'($urandom_range(1, 12)));
    end

    div_num = 11'd3;
    gate = 1'b0; tick(20);
    check("idle_busy", 16'(busy), 16'd0);
    check("idle_sample", sample_out, 16'h7FFF);

    // retrigger during release at level 155
    gate = 1'b1; tick(20);
    gate = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick(1);
      if (env_level === 8'd155) found = 1;
    end
    check("retrig_wait", 16'(found), 16'd1);
    gate = 1'b1; tick(8);
    check("retrig_sustain", 16'(env_level), 16'd255);
    gate = 1'b0; tick(20);

    // signed extremes at full envelope
    div_num = 11'd4;
    fill(16'h0000);
    gate = 1'b1; tick(2);
    check("phase_reset", 16'(ram_addr), 16'd0);
    tick(30);
    check("neg_extreme", sample_out, 16'h007F);
    gate = 1'b0; tick(20);
    fill(16'hFFFF);
    gate = 1'b1; tick(32);
    check("pos_extreme", sample_out, 16'hFF7F);
    gate = 1'b0; tick(20);
    fill(16'h7FFF);
    gate = 1'b1; tick(32);
    check("mid_level", sample_out, 16'h7FFF);
    gate = 1'b0; tick(20);

    foreach (mem[i]) mem[i] = 16'($urandom);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) gate = ~gate;
      if ($urandom_range(0, 3) == 0) div_num = 11'($urandom_range(0, 12));
      if (i == 75) begin
        rst = 1'b1; tick(2); rst = 1'b0;
      end
      tick(int'($urandom_range(1, 40)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/tone_voice.md
# tone_voice

Single-voice wavetable tone generator with a gated linear attack/release envelope. It sits between the note sequencer and the PWM generator:
- The sequencer supplies `gate` and `div_num`.
- This block steps the 512x16 wavetable RAM address at the programmed rate and scales each RAM word by the envelope.
- It presents a 16-bit offset-binary sample whose rest level is `SILENT`.

This replaces the hard `OE ? rdata : silent` switch, which produced clicks on note start and stop.

## Interface
- `DIV_W`, 11: width of `div_num`.
- `ADDR_W`, 9: wavetable address width.
- `ENV_DIV`, 64: clocks per envelope step.
- `ATK_STEP`, 8: envelope increment per step during attack.
- `REL_STEP`, 4: envelope decrement per step during release.
- `SILENT`, 16'h7FFF: offset-binary rest level.

- `clk` in 1: single clock for all logic and for the RAM.
- `rst` in 1: synchronous, active-high reset.
- `gate` in 1: note on (1) / note off (0) from the sequencer; level-sensitive, edges detected internally.
- `div_num` in `DIV_W`: clocks per wavetable step.
- `ram_addr` out `ADDR_W`: registered wavetable read address.
- `ram_rdata` in 16: RAM read data, valid exactly 1 clock after `ram_addr` changes.
- `sample_out` out 16: scaled offset-binary sample for the PWM generator.
- `sample_valid` out 1: one-clock pulse when `sample_out` updates.
- `env_level` out 8: current envelope value, 0..255.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Reset values:**
  - `ram_addr` = 0, `sample_out` = `SILENT`, `sample_valid` = 0, `env_level` = 0, `busy` = 0.
  - FSM = IDLE, divider count = 0, envelope prescaler = 0, registered `gate` = 0.
- **Rate divider:**
  - `cnt` counts 0..`eff_div`-1, where `eff_div` = max(`div_num`, 2).
  - At `cnt` == `eff_div`-1: `cnt` <= 0 and `ram_addr` <= `ram_addr`+1. `ram_addr` wraps 511 -> 0.
  - `div_num` is sampled every clock. A change shortens or lengthens the current period; if `cnt` already exceeds the new `eff_div`-1, the terminal condition is `cnt` >= `eff_div`-1.
  - The divider runs only when not IDLE.
- **Phase reset:** a `gate` rising edge while in IDLE sets `ram_addr` <= 0 and `cnt` <= 0 on that edge.
- **Envelope FSM:** states are IDLE, ATTACK, SUSTAIN, RELEASE. The prescaler counts `ENV_DIV` clocks, steps the envelope once, then restarts.
  - IDLE -> ATTACK on a `gate` rise. `env_level` = 0.
  - ATTACK: `env_level` += `ATK_STEP` per step, saturating at 255; reaching 255 -> SUSTAIN.
  - SUSTAIN: `env_level` = 255; stays until `gate` falls.
  - `gate` fall in ATTACK or SUSTAIN -> RELEASE.
  - RELEASE: `env_level` -= `REL_STEP` per step, floored at 0; reaching 0 -> IDLE.
  - `gate` rise in RELEASE -> ATTACK from the current level. There is no drop to 0 and no phase reset.
  - The prescaler clears on every state change.
- **Scaling:**
  - `d` = `ram_rdata` - `SILENT` as a 17-bit signed value.
  - `p` = `d` * {1'b0, `env_level`} as a 26-bit signed value.
  - `s` = `SILENT` + (`p` >>> 8), arithmetic shift.
  - Because `env_level` <= 255, `s` always lies in 0..16'hFFFF; no saturation logic is needed.
- **Output in IDLE:** `sample_out` is held at `SILENT` and `sample_valid` = 0.

## Timing
- Wavetable step edge E: `ram_addr` changes at E.
- E+1: `ram_rdata` is valid.
- E+2: the `d` * `env_level` product is registered. `env_level` is sampled at this edge.
- E+3: `sample_out` updates and `sample_valid` is high for that one clock.
- Total latency from `ram_addr` change to `sample_out` is 3 clocks. The pipeline accepts a new address every clock, so `div_num` = 2 is legal.
- `gate` is registered once; the FSM reacts on the clock after the registered edge is seen (2 clocks after the input pin changes).
- Entering IDLE forces `sample_out` <= `SILENT` on the same edge. Samples already in the pipeline are dropped.
- `rst` mid-note returns every register to its reset value on the next edge, regardless of state.

## Test plan
- **Reset:** assert `rst` 3 clocks with `gate`=1 -> `sample_out`=16'h7FFF, `ram_addr`=0, `busy`=0, no `sample_valid` pulses while `rst` is high.
- **Address rate:** `div_num`=4, `gate`=1 -> `ram_addr` increments every 4 clocks, wraps 511->0; `sample_valid` pulses exactly 3 clocks after each `ram_addr` change. Repeat with `div_num`=0 and 1 -> steps every 2 clocks.
- **Attack envelope:** `ENV_DIV`=2, `ATK_STEP`=64, `gate` rise -> `env_level` 0,64,128,192,255, then SUSTAIN. With RAM model `rdata`=16'hFFFF and `env_level`=128 -> `sample_out`=16'hBFFF.
- **Release:** `REL_STEP`=100 from 255 -> 155, 55, 0, then IDLE; `busy` falls and `sample_out` returns to 16'h7FFF on the edge IDLE is entered.
- **Retrigger:** `gate` rise during RELEASE at `env_level`=155 -> ATTACK continues from 155 with no `ram_addr` reset. `gate` rise from IDLE -> `ram_addr`=0.
- **Signed extremes:** `rdata`=16'h0000 with `env_level`=255 -> `sample_out`=16'h007F. `rdata`=16'h7FFF at any level -> 16'h7FFF.
